// File: rtl/io_arb_pkg.sv
// Shared types and constants for the I/O bus arbiter between the AVR core and the debug master.
package io_arb_pkg;

  localparam int unsigned ADR_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FAIR_W = 3;
  localparam int unsigned TMO_W  = 4;

  localparam logic [ADR_W-1:0] SPL_ADR  = 6'h3D;
  localparam logic [ADR_W-1:0] SPH_ADR  = 6'h3E;
  localparam logic [ADR_W-1:0] SREG_ADR = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE_WAIT,
    ST_DBG_ACC,
    ST_DBG_ACK
  } io_arb_st_t;

  // Debug command captured at grant time
  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] wdata;
  } dbg_cmd_t;

endpackage

// File: rtl/io_arb_wait_timer.sv
// Counts io_rdy-low cycles of one bus access; flags the cycle on which the access must be aborted.
module io_arb_wait_timer
  import io_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic timeout
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt;

  // Clear wins over load so a completing access always leaves the counter at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TMO_W'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign timeout = (cnt == TMO_W'(LIMIT));

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates the 64-entry I/O register bus between the core (priority) and a debug/DMA master,
// with wait-state insertion on io_rdy and abort of hung accesses.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT   = 4,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic              cp2,
  input  logic              ireset,
  input  logic [ADR_W-1:0]  core_adr,
  input  logic              core_iore,
  input  logic              core_iowe,
  input  logic [DATA_W-1:0] core_dbusout,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADR_W-1:0]  dbg_adr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADR_W-1:0]  io_adr,
  output logic              io_iore,
  output logic              io_iowe,
  output logic [DATA_W-1:0] io_dbusout,
  input  logic [DATA_W-1:0] io_dbusin,
  input  logic              io_rdy,
  output logic              bus_err
);

  io_arb_st_t        state, state_nx;
  logic [FAIR_W-1:0] fair_cnt, fair_nx;
  dbg_cmd_t          cmd, cmd_nx;
  logic [DATA_W-1:0] rdata_nx;
  logic              err_q, err_nx;

  logic              core_acc, fair_hit;
  logic              tmr_load, tmr_inc, tmr_clr, tmo_hit;

  logic [ADR_W-1:0]  adr_c;
  logic [DATA_W-1:0] dbusout_c;
  logic              iore_c, iowe_c, stall_c, ack_c, berr_c;

  assign core_acc = core_iore | core_iowe;
  assign fair_hit = (fair_cnt == FAIR_W'(FAIR_LIMIT));

  io_arb_wait_timer #(
    .LIMIT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk     (cp2),
    .rst_n   (ireset),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .clr     (tmr_clr),
    .timeout (tmo_hit)
  );

  // Next-state and bus-mux logic; the bus follows the core with no added latency in IDLE/CORE_WAIT
  always_comb begin
    state_nx  = state;
    fair_nx   = fair_cnt;
    cmd_nx    = cmd;
    rdata_nx  = dbg_rdata;
    err_nx    = 1'b0;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    tmr_clr   = 1'b0;
    adr_c     = core_adr;
    dbusout_c = core_dbusout;
    iore_c    = 1'b0;
    iowe_c    = 1'b0;
    stall_c   = 1'b0;
    ack_c     = 1'b0;
    berr_c    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (dbg_req && (!core_acc || fair_hit)) begin
          cmd_nx   = '{we: dbg_we, adr: dbg_adr, wdata: dbg_wdata};
          stall_c  = core_acc;
          fair_nx  = '0;
          tmr_load = 1'b1;
          state_nx = ST_DBG_ACC;
        end else if (core_acc) begin
          iore_c = core_iore;
          iowe_c = core_iowe;
          if (io_rdy) begin
            if (dbg_req) fair_nx = fair_cnt + FAIR_W'(1);
          end else begin
            stall_c  = 1'b1;
            tmr_load = 1'b1;
            state_nx = ST_CORE_WAIT;
          end
        end
      end

      ST_CORE_WAIT: begin
        iore_c = core_iore;
        iowe_c = core_iowe;
        if (io_rdy) begin
          tmr_clr  = 1'b1;
          state_nx = ST_IDLE;
        end else if (tmo_hit) begin
          berr_c   = 1'b1;
          tmr_clr  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          tmr_inc = 1'b1;
        end
      end

      ST_DBG_ACC: begin
        adr_c     = cmd.adr;
        dbusout_c = cmd.wdata;
        iore_c    = !cmd.we;
        iowe_c    = cmd.we;
        stall_c   = core_acc;
        if (io_rdy) begin
          if (!cmd.we) rdata_nx = io_dbusin;
          tmr_clr  = 1'b1;
          state_nx = ST_DBG_ACK;
        end else if (tmo_hit) begin
          rdata_nx = 8'hFF;
          err_nx   = 1'b1;
          tmr_clr  = 1'b1;
          state_nx = ST_DBG_ACK;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      ST_DBG_ACK: begin
        ack_c    = 1'b1;
        berr_c   = err_q;
        stall_c  = core_acc;
        state_nx = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase

    if (!dbg_req) fair_nx = '0;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state     <= ST_IDLE;
      fair_cnt  <= '0;
      cmd       <= '0;
      dbg_rdata <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      fair_cnt  <= fair_nx;
      cmd       <= cmd_nx;
      dbg_rdata <= rdata_nx;
      err_q     <= err_nx;
    end
  end

  // Strobes and handshakes are forced low for as long as reset is held
  assign io_adr     = adr_c;
  assign io_dbusout = dbusout_c;
  assign io_iore    = ireset & iore_c;
  assign io_iowe    = ireset & iowe_c;
  assign core_stall = ireset & stall_c;
  assign dbg_ack    = ireset & ack_c;
  assign bus_err    = ireset & berr_c;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: per-cycle comparison against a transaction-level model plus literal checks.
module tb_io_bus_arbiter;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] core_adr;
  logic       core_iore, core_iowe;
  logic [7:0] core_dbusout;
  logic       core_stall;
  logic       dbg_req, dbg_we;
  logic [5:0] dbg_adr;
  logic [7:0] dbg_wdata;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic [5:0] io_adr;
  logic       io_iore, io_iowe;
  logic [7:0] io_dbusout, io_dbusin;
  logic       io_rdy;
  logic       bus_err;

  int total = 0;
  int bad   = 0;

  always #5 cp2 = ~cp2;

  io_bus_arbiter dut (
    .cp2          (cp2),
    .ireset       (ireset),
    .core_adr     (core_adr),
    .core_iore    (core_iore),
    .core_iowe    (core_iowe),
    .core_dbusout (core_dbusout),
    .core_stall   (core_stall),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_adr      (dbg_adr),
    .dbg_wdata    (dbg_wdata),
    .dbg_ack      (dbg_ack),
    .dbg_rdata    (dbg_rdata),
    .io_adr       (io_adr),
    .io_iore      (io_iore),
    .io_iowe      (io_iowe),
    .io_dbusout   (io_dbusout),
    .io_dbusin    (io_dbusin),
    .io_rdy       (io_rdy),
    .bus_err      (bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks which access owns the bus and how many low-ready cycles it has seen
  int         m_dbg_phase = 0;   // 0 none, 1 on bus, 2 acknowledging
  int         m_core_lows = 0;   // low-ready cycles already seen by a stalled core access
  int         m_dbg_lows  = 0;
  int         m_fair      = 0;
  logic       m_we  = 1'b0;
  logic [5:0] m_adr = '0;
  logic [7:0] m_wd  = '0;
  logic [7:0] m_rdata = '0;
  logic       m_err = 1'b0;

  always @(negedge cp2) begin : model_cmp
    logic       e_re, e_we, e_stall, e_ack, e_berr, cacc;
    logic [5:0] e_adr;
    logic [7:0] e_do, e_rd;
    cacc = core_iore | core_iowe;
    e_re = 0; e_we = 0; e_stall = 0; e_ack = 0; e_berr = 0;
    e_adr = core_adr; e_do = core_dbusout; e_rd = m_rdata;
    if (!ireset) begin
      e_rd = '0;
      m_dbg_phase = 0; m_core_lows = 0; m_dbg_lows = 0; m_fair = 0;
      m_rdata = '0; m_err = 0;
    end else begin
      if (m_dbg_phase == 2) begin
        e_ack = 1; e_berr = m_err; e_stall = cacc;
        m_err = 0; m_dbg_phase = 0;
      end else if (m_dbg_phase == 1) begin
        e_adr = m_adr; e_do = m_wd; e_re = !m_we; e_we = m_we; e_stall = cacc;
        if (io_rdy) begin
          if (!m_we) m_rdata = io_dbusin;
          m_dbg_phase = 2;
        end else if (m_dbg_lows + 1 == 15) begin
          m_rdata = 8'hFF; m_err = 1; m_dbg_phase = 2;
        end else begin
          m_dbg_lows++;
        end
      end else if (m_core_lows > 0) begin
        e_re = core_iore; e_we = core_iowe;
        if (io_rdy) m_core_lows = 0;
        else if (m_core_lows + 1 == 16) begin e_berr = 1; m_core_lows = 0; end
        else begin e_stall = 1; m_core_lows++; end
      end else if (dbg_req && (!cacc || m_fair == 4)) begin
        e_stall = cacc;
        m_we = dbg_we; m_adr = dbg_adr; m_wd = dbg_wdata;
        m_fair = 0; m_dbg_lows = 0; m_dbg_phase = 1;
      end else if (cacc) begin
        e_re = core_iore; e_we = core_iowe;
        if (io_rdy) m_fair += int'(dbg_req);
        else begin e_stall = 1; m_core_lows = 1; end
      end
      if (!dbg_req) m_fair = 0;
    end
    chk("m_iore", 32'(io_iore), 32'(e_re));
    chk("m_iowe", 32'(io_iowe), 32'(e_we));
    chk("m_stall", 32'(core_stall), 32'(e_stall));
    chk("m_ack", 32'(dbg_ack), 32'(e_ack));
    chk("m_berr", 32'(bus_err), 32'(e_berr));
    chk("m_rdata", 32'(dbg_rdata), 32'(e_rd));
    if (e_re || e_we) chk("m_adr", 32'(io_adr), 32'(e_adr));
    if (e_we) chk("m_dout", 32'(io_dbusout), 32'(e_do));
  end

  task automatic tick();
    @(posedge cp2); #1;
  endtask

  task automatic smp();
    @(negedge cp2); #1;
  endtask

  initial begin
    int ack_i, stall_n, first_stall, core_done, iore_n, rise_n, iowe_n, berr_n, berr_i;
    logic prev, berr_at_ack, stall_at_berr;

    ireset = 0; core_adr = 6'h3F; core_iore = 1; core_iowe = 0; core_dbusout = 0;
    dbg_req = 0; dbg_we = 0; dbg_adr = 0; dbg_wdata = 0; io_dbusin = 0; io_rdy = 1;
    tick();
    smp();
    chk("rst_iore_forced", 32'(io_iore), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rdata", 32'(dbg_rdata), 32'h00);
    tick();
    core_iore = 0; ireset = 1;
    tick();

    // Core write to SREG passes straight through
    core_adr = 6'h3F; core_dbusout = 8'h80; core_iowe = 1;
    smp();
    chk("cw_iowe", 32'(io_iowe), 32'd1);
    chk("cw_adr", 32'(io_adr), 32'h3F);
    chk("cw_data", 32'(io_dbusout), 32'h80);
    chk("cw_stall", 32'(core_stall), 32'd0);
    tick();
    core_dbusout = 8'h81;
    smp();
    chk("cw2_iowe", 32'(io_iowe), 32'd1);
    chk("cw2_data", 32'(io_dbusout), 32'h81);
    tick();
    core_iowe = 0;
    tick();

    // Debug read of SPL with idle core
    dbg_req = 1; dbg_we = 0; dbg_adr = 6'h3D; io_dbusin = 8'hA5;
    smp();
    chk("dr_c0_iore", 32'(io_iore), 32'd0);
    chk("dr_c0_ack", 32'(dbg_ack), 32'd0);
    tick();
    smp();
    chk("dr_c1_iore", 32'(io_iore), 32'd1);
    chk("dr_c1_adr", 32'(io_adr), 32'h3D);
    tick();
    smp();
    chk("dr_c2_ack", 32'(dbg_ack), 32'd1);
    chk("dr_c2_rdata", 32'(dbg_rdata), 32'hA5);
    tick();
    dbg_req = 0; io_dbusin = 8'h00;
    smp();
    chk("dr_c3_ack", 32'(dbg_ack), 32'd0);
    chk("dr_c3_hold", 32'(dbg_rdata), 32'hA5);
    tick();

    // Fairness: core reads every cycle while debug waits
    core_adr = 6'h10; core_iore = 1;
    dbg_req = 1; dbg_we = 0; dbg_adr = 6'h3E; io_dbusin = 8'h5A;
    ack_i = -1; stall_n = 0; first_stall = -1; core_done = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (core_stall) begin
        stall_n++;
        if (first_stall < 0) first_stall = i;
      end
      if (first_stall < 0 && io_iore && io_adr == 6'h10) core_done++;
      if (dbg_ack && ack_i < 0) ack_i = i;
      tick();
      if (ack_i >= 0) dbg_req = 0;
    end
    core_iore = 0;
    chk("fair_first_stall", 32'(first_stall), 32'd4);
    chk("fair_core_done", 32'(core_done), 32'd4);
    chk("fair_stall_cnt", 32'(stall_n), 32'd3);
    chk("fair_ack_cycle", 32'(ack_i), 32'd6);
    chk("fair_rdata", 32'(dbg_rdata), 32'h5A);
    tick();

    // Core read with three wait states
    core_adr = 6'h3F; stall_n = 0; iore_n = 0; rise_n = 0; prev = 0;
    for (int i = 0; i < 6; i++) begin
      core_iore = (i <= 3);
      io_rdy = (i >= 3);
      smp();
      if (core_stall) stall_n++;
      if (io_iore) iore_n++;
      if (io_iore && !prev) rise_n++;
      prev = io_iore;
      tick();
    end
    chk("cwait_stall_cnt", 32'(stall_n), 32'd3);
    chk("cwait_iore_cnt", 32'(iore_n), 32'd4);
    chk("cwait_windows", 32'(rise_n), 32'd1);
    core_iore = 0; io_rdy = 1;

    // Debug write with io_rdy stuck low
    dbg_req = 1; dbg_we = 1; dbg_adr = 6'h3E; dbg_wdata = 8'h77; io_rdy = 0;
    ack_i = -1; iowe_n = 0; berr_n = 0; berr_at_ack = 0;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (io_iowe) iowe_n++;
      if (bus_err) berr_n++;
      if (dbg_ack && ack_i < 0) begin ack_i = i; berr_at_ack = bus_err; end
      tick();
      if (ack_i >= 0) begin dbg_req = 0; io_rdy = 1; end
      if (ack_i >= 0 && i >= ack_i + 2) break;
    end
    chk("dtmo_ack_cycle", 32'(ack_i), 32'd16);
    chk("dtmo_berr_with_ack", 32'(berr_at_ack), 32'd1);
    chk("dtmo_berr_cnt", 32'(berr_n), 32'd1);
    chk("dtmo_iowe_cnt", 32'(iowe_n), 32'd15);
    chk("dtmo_rdata", 32'(dbg_rdata), 32'hFF);
    dbg_req = 0; io_rdy = 1;

    // Core write with io_rdy stuck low
    core_adr = 6'h3D; core_dbusout = 8'h11; core_iowe = 1; io_rdy = 0;
    stall_n = 0; berr_i = -1; stall_at_berr = 1;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (core_stall) stall_n++;
      if (bus_err && berr_i < 0) begin berr_i = i; stall_at_berr = core_stall; end
      tick();
      if (berr_i >= 0) begin core_iowe = 0; io_rdy = 1; end
    end
    chk("ctmo_stall_cnt", 32'(stall_n), 32'd15);
    chk("ctmo_berr_cycle", 32'(berr_i), 32'd15);
    chk("ctmo_stall_at_berr", 32'(stall_at_berr), 32'd0);

    // Reset while a debug read is on the bus
    dbg_req = 1; dbg_we = 0; dbg_adr = 6'h3D; io_rdy = 0;
    tick();
    smp();
    chk("rmid_iore_before", 32'(io_iore), 32'd1);
    tick();
    ireset = 0;
    #1;
    chk("rmid_iore_now", 32'(io_iore), 32'd0);
    chk("rmid_ack_now", 32'(dbg_ack), 32'd0);
    chk("rmid_rdata_clr", 32'(dbg_rdata), 32'h00);
    dbg_req = 0; io_rdy = 1;
    tick();
    ireset = 1;
    ack_i = 0;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (dbg_ack) ack_i++;
      tick();
    end
    chk("rmid_no_ack", 32'(ack_i), 32'd0);
    core_adr = 6'h3E; core_dbusout = 8'h42; core_iowe = 1;
    smp();
    chk("rmid_idle_iowe", 32'(io_iowe), 32'd1);
    chk("rmid_idle_stall", 32'(core_stall), 32'd0);
    tick();
    core_iowe = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
